// File: rtl/pt_pkg.sv
// Shared constants and state encodings for the PT2262 UART command front-end.
package pt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         WORD_W    = 24;

  typedef enum logic [1:0] {
    CB_ZERO = 2'b00,
    CB_ONE  = 2'b01,
    CB_HIZ  = 2'b10,
    CB_OFF  = 2'b11
  } codebit_t;

  typedef enum logic [2:0] {
    P_SYNC, P_REP, P_D2, P_D1, P_D0, P_CHK
  } parse_state_t;

  typedef enum logic [1:0] {
    E_ARM, E_HOLD, E_WAIT
  } eng_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] rep, input logic [7:0] d2,
                                           input logic [7:0] d1, input logic [7:0] d0);
    return rep ^ d2 ^ d1 ^ d0;
  endfunction

endpackage

// File: rtl/pt_uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, glitch-filtered start bit, centre sampling.
module pt_uart_rx
  import pt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       stop_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic            rx_meta, rx_sync, rx_prev;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;

  // Synchronizer resets to the idle line level so reset never looks like a start edge.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            state <= RX_IDLE;
            if (rx_sync) begin
              rx_byte    <= shreg;
              byte_valid <= 1'b1;
            end else begin
              stop_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign rx_busy = (state != RX_IDLE);

endmodule

// File: rtl/pt_uart_cmd.sv
// UART command parser and repeat engine driving ad/ld into pt_enc.
// Optional CHK byte enabled by defining PT_CMD_CHECKSUM_EN.
module pt_uart_cmd
  import pt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              enc_done,
  output logic [WORD_W-1:0] ad,
  output logic              ld,
  output logic              busy,
  output logic              frame_ok,
  output logic              frame_err
);

  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TO_CYCLES + 1);

  logic [7:0]        rx_byte;
  logic              byte_valid, stop_err, rx_busy;
  parse_state_t      pstate;
  eng_state_t        estate;
  logic [7:0]        rep_q, d2_q, d1_q;
  logic [TW-1:0]     timer;
  logic [7:0]        rem;
  logic              hold_cnt;
  logic              accept, chk_bad;
  logic [WORD_W-1:0] new_word;

  pt_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .stop_err   (stop_err),
    .rx_busy    (rx_busy)
  );

`ifdef PT_CMD_CHECKSUM_EN
  logic [7:0] d0_q;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    accept   = 1'b0;
    chk_bad  = 1'b0;
`ifdef PT_CMD_CHECKSUM_EN
    new_word = {d2_q, d1_q, d0_q};
    if (byte_valid && pstate == P_CHK) begin
      if (rx_byte == frame_chk(rep_q, d2_q, d1_q, d0_q)) accept  = 1'b1;
      else                                               chk_bad = 1'b1;
    end
`else
    new_word = {d2_q, d1_q, rx_byte};
    if (byte_valid && pstate == P_D0) accept = 1'b1;
`endif
  end

  // Timer only runs on an idle line mid-frame, so it measures the gap between bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pstate    <= P_SYNC;
      rep_q     <= '0;
      d2_q      <= '0;
      d1_q      <= '0;
`ifdef PT_CMD_CHECKSUM_EN
      d0_q      <= '0;
`endif
      timer     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (pstate == P_SYNC || rx_busy || byte_valid) timer <= '0;
      else                                           timer <= timer + 1'b1;

      if (stop_err) begin
        frame_err <= 1'b1;
        pstate    <= P_SYNC;
      end else if (byte_valid) begin
        case (pstate)
          P_SYNC: if (rx_byte == SYNC_BYTE) pstate <= P_REP;
          P_REP:  begin rep_q <= rx_byte; pstate <= P_D2; end
          P_D2:   begin d2_q  <= rx_byte; pstate <= P_D1; end
          P_D1:   begin d1_q  <= rx_byte; pstate <= P_D0; end
`ifdef PT_CMD_CHECKSUM_EN
          P_D0:   begin d0_q  <= rx_byte; pstate <= P_CHK; end
`else
          P_D0:   pstate <= P_SYNC;
`endif
          P_CHK:  begin frame_err <= chk_bad; pstate <= P_SYNC; end
          default: pstate <= P_SYNC;
        endcase
      end else if (timer == TW'(TO_CYCLES)) begin
        frame_err <= 1'b1;
        pstate    <= P_SYNC;
      end
    end
  end

  // A frame accepted while ARM fires still lets that ld out, but its REP overrides rem.
  always_ff @(posedge clk) begin
    if (rst) begin
      ad       <= '0;
      rem      <= '0;
      frame_ok <= 1'b0;
      ld       <= 1'b0;
      busy     <= 1'b0;
      estate   <= E_ARM;
      hold_cnt <= 1'b0;
    end else begin
      frame_ok <= accept;
      ld       <= 1'b0;
      busy     <= (rem != 8'd0) || !enc_done;
      case (estate)
        E_ARM: begin
          if (enc_done && rem != 8'd0) begin
            ld       <= 1'b1;
            rem      <= rem - 8'd1;
            hold_cnt <= 1'b0;
            estate   <= E_HOLD;
          end
        end
        E_HOLD: begin
          if (hold_cnt) estate   <= E_WAIT;
          else          hold_cnt <= 1'b1;
        end
        E_WAIT: if (enc_done) estate <= E_ARM;
        default: estate <= E_ARM;
      endcase
      if (accept) begin
        ad  <= new_word;
        rem <= rep_q;
      end
    end
  end

endmodule

// File: tb/tb_pt_uart_cmd.sv
// Self-checking bench for pt_uart_cmd with a behavioural pt_enc stand-in and UART driver.
module tb_pt_uart_cmd;

  localparam int CPB      = 16;
  localparam int TOB      = 20;
  localparam int WORD_CYC = 40;

  logic        clk = 1'b0;
  logic        rst, rx, enc_done;
  logic [23:0] ad;
  logic        ld, busy, frame_ok, frame_err;

  int checks = 0;
  int errors = 0;

  int          ok_cnt = 0, err_cnt = 0, ld_cnt = 0, ld_bad = 0, ld_at_ok = 0;
  logic [23:0] last_ld_ad = '0;

  always #5 clk = ~clk;

  pt_uart_cmd #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .enc_done  (enc_done),
    .ad        (ad),
    .ld        (ld),
    .busy      (busy),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  // Encoder stand-in: done drops two cycles after a load, stays low for one word time.
  int   enc_cnt;
  logic enc_arm;
  always @(posedge clk) begin
    if (rst) begin
      enc_done <= 1'b1;
      enc_cnt  <= 0;
      enc_arm  <= 1'b0;
    end else begin
      enc_arm <= ld && enc_done;
      if (enc_arm) begin
        enc_done <= 1'b0;
        enc_cnt  <= WORD_CYC;
      end else if (!enc_done) begin
        if (enc_cnt == 0) enc_done <= 1'b1;
        else              enc_cnt  <= enc_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (ld) begin
        ld_cnt     <= ld_cnt + 1;
        last_ld_ad <= ad;
        if (!enc_done) ld_bad <= ld_bad + 1;
      end
      if (frame_ok) begin
        ok_cnt   <= ok_cnt + 1;
        ld_at_ok <= ld_cnt + (ld ? 1 : 0);
      end
      if (frame_err) err_cnt <= err_cnt + 1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic bit_time(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    bit_time(1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bit_time(1);
    end
    rx = stop_bit;
    bit_time(1);
    rx = 1'b1;
    if (!stop_bit) bit_time(1);
  endtask

  task automatic send_frame(input logic [7:0] rep, input logic [23:0] cw);
    send_byte(8'hA5, 1'b1);
    send_byte(rep, 1'b1);
    send_byte(cw[23:16], 1'b1);
    send_byte(cw[15:8], 1'b1);
    send_byte(cw[7:0], 1'b1);
`ifdef PT_CMD_CHECKSUM_EN
    send_byte(rep ^ cw[23:16] ^ cw[15:8] ^ cw[7:0], 1'b1);
`endif
  endtask

  task automatic wait_idle(input string name);
    int run, n;
    run = 0;
    n   = 0;
    while (run < 8 && n < 20000) begin
      @(negedge clk);
      n++;
      if (!busy && enc_done) run++;
      else                   run = 0;
    end
    checks++;
    if (run < 8) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b enc_done=%0b, required busy=0 enc_done=1", name, busy, enc_done);
    end
  endtask

  task automatic wait_lds(input string name, input int target);
    int n;
    n = 0;
    while (ld_cnt < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ld_cnt < target) begin
      errors++;
      $display("FAIL %s_ld_wait: ld count %0d, required at least %0d", name, ld_cnt, target);
    end
  endtask

  // Reference: a good frame yields one frame_ok, ad = codeword and REP loads, all while done is high.
  task automatic run_frame(input string name, input logic [7:0] rep, input logic [23:0] cw);
    int ok0, err0, ld0, bad0;
    ok0 = ok_cnt; err0 = err_cnt; ld0 = ld_cnt; bad0 = ld_bad;
    send_frame(rep, cw);
    wait_idle(name);
    checks++;
    if (ok_cnt - ok0 !== 1) begin
      errors++; $display("FAIL %s_ok: frame_ok count %0d, required 1", name, ok_cnt - ok0);
    end
    checks++;
    if (err_cnt - err0 !== 0) begin
      errors++; $display("FAIL %s_err: frame_err count %0d, required 0", name, err_cnt - err0);
    end
    checks++;
    if (ad !== cw) begin
      errors++; $display("FAIL %s_ad: ad %h, required %h", name, ad, cw);
    end
    checks++;
    if (ld_cnt - ld0 !== int'(rep)) begin
      errors++; $display("FAIL %s_ld: ld count %0d, required %0d", name, ld_cnt - ld0, rep);
    end
    if (rep != 8'd0) begin
      checks++;
      if (last_ld_ad !== cw) begin
        errors++; $display("FAIL %s_ld_ad: ad at ld %h, required %h", name, last_ld_ad, cw);
      end
    end
    checks++;
    if (ld_bad - bad0 !== 0) begin
      errors++; $display("FAIL %s_ld_done: %0d loads while done low, required 0", name, ld_bad - bad0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ad, ld, busy, frame_ok, frame_err} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: ad=%h ld=%0b busy=%0b ok=%0b err=%0b, required all 0",
               ad, ld, busy, frame_ok, frame_err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ld !== 1'b0) begin
      errors++; $display("FAIL reset_ld_after: ld %0b, required 0", ld);
    end
  endtask

  task automatic test_basic();
    run_frame("basic", 8'd3, 24'h123456);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      run_frame("random", 8'($urandom_range(1, 3)), 24'($urandom));
    end
  endtask

  task automatic test_noise();
    int ok0, err0;
    ok0 = ok_cnt; err0 = err_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    bit_time(30);
    checks++;
    if (err_cnt - err0 !== 0 || ok_cnt - ok0 !== 0) begin
      errors++;
      $display("FAIL noise_silent: err %0d ok %0d, required 0 and 0", err_cnt - err0, ok_cnt - ok0);
    end
    run_frame("noise", 8'd2, 24'($urandom));
  endtask

  task automatic test_framing();
    int ok0, err0, ld0;
    ok0 = ok_cnt; err0 = err_cnt; ld0 = ld_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'($urandom), 1'b0);
    bit_time(4);
    checks++;
    if (err_cnt - err0 !== 1) begin
      errors++; $display("FAIL framing_err: frame_err count %0d, required 1", err_cnt - err0);
    end
    bit_time(TOB + 5);
    checks++;
    if (err_cnt - err0 !== 1 || ok_cnt - ok0 !== 0 || ld_cnt - ld0 !== 0) begin
      errors++;
      $display("FAIL framing_sync: err %0d ok %0d ld %0d, required 1 0 0",
               err_cnt - err0, ok_cnt - ok0, ld_cnt - ld0);
    end
    run_frame("framing_after", 8'd1, 24'($urandom));
  endtask

  task automatic test_checksum();
`ifdef PT_CMD_CHECKSUM_EN
    int ok0, err0, ld0;
    ok0 = ok_cnt; err0 = err_cnt; ld0 = ld_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_idle("chk_bad");
    checks++;
    if (err_cnt - err0 !== 1 || ok_cnt - ok0 !== 0 || ld_cnt - ld0 !== 0) begin
      errors++;
      $display("FAIL chk_bad: err %0d ok %0d ld %0d, required 1 0 0",
               err_cnt - err0, ok_cnt - ok0, ld_cnt - ld0);
    end
    run_frame("chk_good", 8'd1, 24'hAABBCC);
`else
    int err0;
    err0 = err_cnt;
    run_frame("chk_off", 8'd1, 24'hAABBCC);
    send_byte(8'h00, 1'b1);
    bit_time(4);
    checks++;
    if (err_cnt - err0 !== 0) begin
      errors++; $display("FAIL chk_off_trailing: frame_err count %0d, required 0", err_cnt - err0);
    end
`endif
  endtask

  task automatic test_timeout();
    int ok0, err0, ld0;
    ok0 = ok_cnt; err0 = err_cnt; ld0 = ld_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    bit_time(25);
    checks++;
    if (err_cnt - err0 !== 1 || ok_cnt - ok0 !== 0 || ld_cnt - ld0 !== 0) begin
      errors++;
      $display("FAIL timeout: err %0d ok %0d ld %0d, required 1 0 0",
               err_cnt - err0, ok_cnt - ok0, ld_cnt - ld0);
    end
    run_frame("timeout_after", 8'd2, 24'($urandom));
  endtask

  task automatic test_override();
    int ok0, ld0;
    logic [23:0] cw2;
    cw2 = 24'h112233;
    ok0 = ok_cnt; ld0 = ld_cnt;
    send_frame(8'd200, 24'($urandom));
    wait_lds("override_run", ld0 + 2);
    send_frame(8'd0, cw2);
    wait_idle("override");
    checks++;
    if (ok_cnt - ok0 !== 2) begin
      errors++; $display("FAIL override_ok: frame_ok count %0d, required 2", ok_cnt - ok0);
    end
    checks++;
    if (ld_cnt !== ld_at_ok) begin
      errors++; $display("FAIL override_stop: ld count %0d, required %0d", ld_cnt, ld_at_ok);
    end
    checks++;
    if (ad !== cw2) begin
      errors++; $display("FAIL override_ad: ad %h, required %h", ad, cw2);
    end
  endtask

  task automatic test_rst_mid();
    int ok0, err0, ld0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h11, 1'b1);
    rx = 1'b0;
    bit_time(3);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ad, ld, busy, frame_ok, frame_err} !== 28'd0) begin
      errors++;
      $display("FAIL rst_frame_outputs: ad=%h ld=%0b busy=%0b ok=%0b err=%0b, required all 0",
               ad, ld, busy, frame_ok, frame_err);
    end
    rx  = 1'b1;
    rst = 1'b0;
    ok0 = ok_cnt; err0 = err_cnt; ld0 = ld_cnt;
    @(negedge clk);
    checks++;
    if (ld !== 1'b0) begin
      errors++; $display("FAIL rst_frame_ld_after: ld %0b, required 0", ld);
    end
    bit_time(TOB + 10);
    checks++;
    if (err_cnt - err0 !== 0 || ok_cnt - ok0 !== 0 || ld_cnt - ld0 !== 0) begin
      errors++;
      $display("FAIL rst_frame_quiet: err %0d ok %0d ld %0d, required 0 0 0",
               err_cnt - err0, ok_cnt - ok0, ld_cnt - ld0);
    end

    ld0 = ld_cnt;
    send_frame(8'd5, 24'($urandom));
    wait_lds("rst_repeat", ld0 + 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ld0 = ld_cnt;
    repeat (6 * WORD_CYC) @(negedge clk);
    checks++;
    if (ld_cnt !== ld0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_repeat_stop: ld %0d busy %0b, required 0 and 0", ld_cnt - ld0, busy);
    end
    run_frame("rst_after", 8'd2, 24'($urandom));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_noise();
    test_framing();
    test_checksum();
    test_timeout();
    test_override();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
